// File: rtl/trng_fifo_rd_arbiter.sv
// Round-robin arbiter for the FIFO1 (TRNG word FIFO) read port.
// The CPU and the UART streaming engine share the port, and UART reads are limited by a
// burst quota that button_pulse loads. Define ARB_STATS_EN to enable the delivery counters.
module trng_fifo_rd_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIFO_LAT  = 1,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo1_empty,
  output logic              fifo1_rd_en,
  input  logic [DATA_W-1:0] fifo1_rd_data,
  input  logic              req_cpu,
  input  logic              req_uart,
  input  logic              button_pulse,
  output logic              gnt_cpu,
  output logic              gnt_uart,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid_cpu,
  output logic              rd_valid_uart,
  output logic              loading_out,
  output logic [15:0]       cnt_cpu,
  output logic [15:0]       cnt_uart
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  localparam logic        WAIT_INIT = 1'(FIFO_LAT - 1);
  localparam logic [15:0] BURST_LD  = 16'(BURST_LEN);

  logic [1:0]  state;
  logic        wait_cnt;
  logic        last_uart;
  logic [15:0] burst_cnt;
  logic [15:0] burst_nxt;
  logic        elig_cpu;
  logic        elig_uart;
  logic        pick_uart;
  logic        grant;

  always_comb begin
    elig_cpu  = req_cpu;
    elig_uart = req_uart && (burst_cnt != '0);
    pick_uart = elig_uart && (!elig_cpu || !last_uart);
    grant     = !fifo1_empty && (elig_cpu || elig_uart);
  end

  // WAIT covers the cycles T+1..T+FIFO_LAT, and rd_data is captured in the last of them.
  // This places DELIVER at T+FIFO_LAT+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= 1'b0;
      last_uart     <= 1'b1;
      fifo1_rd_en   <= 1'b0;
      gnt_cpu       <= 1'b0;
      gnt_uart      <= 1'b0;
      rd_valid_cpu  <= 1'b0;
      rd_valid_uart <= 1'b0;
      rd_data       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            state       <= S_READ;
            fifo1_rd_en <= 1'b1;
            gnt_cpu     <= !pick_uart;
            gnt_uart    <= pick_uart;
            last_uart   <= pick_uart;
          end
        end
        S_READ: begin
          fifo1_rd_en <= 1'b0;
          wait_cnt    <= WAIT_INIT;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 1'b0) begin
            rd_data       <= fifo1_rd_data;
            rd_valid_cpu  <= gnt_cpu;
            rd_valid_uart <= gnt_uart;
            state         <= S_DELIVER;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          rd_valid_cpu  <= 1'b0;
          rd_valid_uart <= 1'b0;
          gnt_cpu       <= 1'b0;
          gnt_uart      <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  // A reload from button_pulse takes priority over the decrement in a UART delivery cycle.
  always_comb begin
    burst_nxt = burst_cnt;
    if (button_pulse)
      burst_nxt = BURST_LD;
    else if (rd_valid_uart && (burst_cnt != '0))
      burst_nxt = burst_cnt - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt   <= '0;
      loading_out <= 1'b0;
    end else begin
      burst_cnt   <= burst_nxt;
      loading_out <= (burst_nxt != '0);
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cpu  <= '0;
      cnt_uart <= '0;
    end else begin
      if (rd_valid_cpu && (cnt_cpu != '1))
        cnt_cpu <= cnt_cpu + 16'd1;
      if (rd_valid_uart && (cnt_uart != '1))
        cnt_uart <= cnt_uart + 16'd1;
    end
  end
`else
  assign cnt_cpu  = '0;
  assign cnt_uart = '0;
`endif

endmodule

// File: tb/tb_trng_fifo_rd_arbiter.sv
// Bench for trng_fifo_rd_arbiter with FIFO_LAT=2 and BURST_LEN=2: a linear sequence of directed steps
// and a random phase, checked every cycle against a transaction-timeline model of the arbiter.
module tb_trng_fifo_rd_arbiter;

  localparam int DW = 32;
  localparam int FL = 2;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo1_empty = 1'b1;
  logic          fifo1_rd_en;
  logic [DW-1:0] fifo1_rd_data;
  logic          req_cpu = 1'b0;
  logic          req_uart = 1'b0;
  logic          button_pulse = 1'b0;
  logic          gnt_cpu, gnt_uart;
  logic [DW-1:0] rd_data;
  logic          rd_valid_cpu, rd_valid_uart;
  logic          loading_out;
  logic [15:0]   cnt_cpu, cnt_uart;

  trng_fifo_rd_arbiter #(.DATA_W(DW), .FIFO_LAT(FL), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .fifo1_empty(fifo1_empty), .fifo1_rd_en(fifo1_rd_en),
    .fifo1_rd_data(fifo1_rd_data), .req_cpu(req_cpu), .req_uart(req_uart),
    .button_pulse(button_pulse), .gnt_cpu(gnt_cpu), .gnt_uart(gnt_uart),
    .rd_data(rd_data), .rd_valid_cpu(rd_valid_cpu), .rd_valid_uart(rd_valid_uart),
    .loading_out(loading_out), .cnt_cpu(cnt_cpu), .cnt_uart(cnt_uart)
  );

  always #5 clk = ~clk;

  // FIFO1 stand-in: data popped at T appears at T+FL; junk otherwise
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pipe [FL];
  logic          force_empty = 1'b0;

  always @(posedge clk) begin : fifo_drv
    logic [DW-1:0] w;
    w = 32'hDEAD_BEEF;
    if (fifo1_rd_en && fq.size() != 0) w = fq.pop_front();
    pipe[0] <= w;
    for (int i = 1; i < FL; i++) pipe[i] <= pipe[i-1];
  end
  assign fifo1_rd_data = pipe[FL-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: a transaction occupies cycles t0 .. t0+FL+1
  logic [DW-1:0] mq[$];
  bit            m_busy = 0, m_own = 0, m_last = 1;
  int            m_t0 = 0, m_quota = 0, m_ccnt = 0, m_ucnt = 0;
  logic [DW-1:0] m_word = '0, m_data = '0;

  // observed events
  int            ob_rd_en = 0, ob_vc = 0, ob_vu = 0;
  int            t_rd_en = -1, t_vc = -1, t_vu = -1, t_fall = -1;
  logic [DW-1:0] d_vc = '0;
  logic [DW:0]   dq[$];
  bit            prev_load = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    mq.push_back(w);
  endtask

  task automatic model_edge();
    bit deliver, eu, pick;
    int q;
    if (rst) begin
      m_busy = 0; m_last = 1; m_quota = 0; m_data = '0; m_ccnt = 0; m_ucnt = 0;
      return;
    end
    deliver = m_busy && (cyc == m_t0 + FL + 1);
    q = m_quota;
    if (m_busy) begin
      if (cyc == m_t0 + FL) m_data = m_word;
      if (deliver) begin
        m_busy = 0;
        if (m_own) m_ucnt = (m_ucnt < 65535) ? m_ucnt + 1 : m_ucnt;
        else       m_ccnt = (m_ccnt < 65535) ? m_ccnt + 1 : m_ccnt;
      end
    end else begin
      eu = req_uart && (q != 0);
      if (!fifo1_empty && (req_cpu || eu)) begin
        pick   = eu && (!req_cpu || !m_last);
        m_busy = 1; m_t0 = cyc + 1; m_own = pick; m_last = pick;
        m_word = (mq.size() != 0) ? mq.pop_front() : 32'hDEAD_BEEF;
      end
    end
    if (button_pulse) m_quota = BL;
    else if (deliver && m_own && m_quota > 0) m_quota--;
  endtask

  task automatic check_outputs();
    int n;
    n = cyc + 1;
    chk("rd_en",     fifo1_rd_en,   m_busy && n == m_t0);
    chk("gnt_cpu",   gnt_cpu,       m_busy && !m_own);
    chk("gnt_uart",  gnt_uart,      m_busy && m_own);
    chk("valid_cpu", rd_valid_cpu,  m_busy && !m_own && n == m_t0 + FL + 1);
    chk("valid_uart",rd_valid_uart, m_busy && m_own && n == m_t0 + FL + 1);
    chk("rd_data",   rd_data,       m_data);
    chk("loading",   loading_out,   m_quota != 0);
`ifdef ARB_STATS_EN
    chk("cnt_cpu",   cnt_cpu,       m_ccnt);
    chk("cnt_uart",  cnt_uart,      m_ucnt);
`else
    chk("cnt_cpu",   cnt_cpu,       0);
    chk("cnt_uart",  cnt_uart,      0);
`endif
    if (fifo1_rd_en === 1'b1) begin ob_rd_en++; t_rd_en = n; end
    if (rd_valid_cpu === 1'b1) begin ob_vc++; t_vc = n; d_vc = rd_data; dq.push_back({1'b0, rd_data}); end
    if (rd_valid_uart === 1'b1) begin ob_vu++; t_vu = n; dq.push_back({1'b1, rd_data}); end
    if (prev_load && loading_out === 1'b0) t_fall = n;
    prev_load = (loading_out === 1'b1);
  endtask

  task automatic step();
    fifo1_empty = force_empty || (fq.size() == 0);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    cyc++;
  endtask

  task automatic pulse_button();
    button_pulse = 1'b1;
    step();
    button_pulse = 1'b0;
  endtask

  int s, c0, c1;
  logic [DW:0] exp_d;

  initial begin
    // reset
    rst = 1'b1; step(); step(); rst = 1'b0; step();

    // CPU only
    push(32'hA5A5_0001);
    req_cpu = 1'b1; s = cyc;
    repeat (8) step();
    req_cpu = 1'b0;
    chk("cpu_rd_en_cycle", t_rd_en - s, 1);
    chk("cpu_valid_cycle", t_vc - s, FL + 2);
    chk("cpu_data", d_vc, 32'hA5A5_0001);

    // contention after reset: CPU, UART, CPU, UART, then CPU alone once quota runs out
    rst = 1'b1; step(); rst = 1'b0;
    pulse_button();
    for (int i = 0; i < 5; i++) push(32'h1111_0000 + i);
    dq.delete();
    req_cpu = 1'b1; req_uart = 1'b1;
    repeat (30) step();
    req_cpu = 1'b0; req_uart = 1'b0;
    repeat (4) step();
    chk("cont_count", dq.size(), 5);
    for (int i = 0; i < 5 && i < dq.size(); i++) begin
      exp_d = {(i % 2 == 1), 32'h1111_0000 + i};
      chk("cont_order", dq[i], exp_d);
    end
`ifdef ARB_STATS_EN
    chk("stats_cpu", cnt_cpu, 3);
    chk("stats_uart", cnt_uart, 2);
`else
    chk("stats_cpu", cnt_cpu, 0);
    chk("stats_uart", cnt_uart, 0);
`endif

    // quota: one press allows exactly BL UART words
    c0 = ob_vu; c1 = ob_rd_en;
    pulse_button();
    for (int i = 0; i < 5; i++) push(32'h2222_0000 + i);
    req_uart = 1'b1;
    repeat (25) step();
    req_uart = 1'b0;
    chk("quota_deliveries", ob_vu - c0, BL);
    chk("quota_rd_en", ob_rd_en - c1, BL);
    chk("quota_loading_fall", t_fall, t_vu + 1);
    repeat (3) step();

    // empty: requests wait while the FIFO reports empty
    c0 = ob_rd_en;
    req_cpu = 1'b1; force_empty = 1'b1;
    repeat (10) step();
    chk("empty_no_rd_en", ob_rd_en - c0, 0);
    force_empty = 1'b0; s = cyc;
    step(); step();
    req_cpu = 1'b0;
    chk("empty_rd_en_cycle", t_rd_en, s + 1);
    repeat (6) step();

    // request dropped during READ still delivers
    c0 = ob_vc;
    req_cpu = 1'b1; step();
    req_cpu = 1'b0;
    repeat (6) step();
    chk("abort_valid", ob_vc - c0, 1);

    // reset during WAIT: no delivery, then the next tie goes to CPU
    push(32'h3333_0001);
    c0 = ob_vc + ob_vu;
    req_cpu = 1'b1; step(); step();
    req_cpu = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    repeat (5) step();
    chk("rst_no_valid", ob_vc + ob_vu - c0, 0);
    pulse_button();
    req_cpu = 1'b1; req_uart = 1'b1; step();
    chk("tie_after_reset", gnt_cpu, 1);
    req_cpu = 1'b0; req_uart = 1'b0;
    repeat (6) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 127) == 0);
      req_cpu      = ($urandom_range(0, 2) == 0);
      req_uart     = ($urandom_range(0, 2) != 0);
      button_pulse = ($urandom_range(0, 23) == 0);
      force_empty  = ($urandom_range(0, 7) == 0);
      if (fq.size() < 3 && $urandom_range(0, 1) == 1) push($urandom);
      step();
    end
    rst = 1'b0; req_cpu = 1'b0; req_uart = 1'b0; button_pulse = 1'b0; force_empty = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
